// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding, fill-scale and pattern mask constants for the camera byte streamer.
package cam_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOAD, S_PRESENT, S_RELEASE, S_FLUSH} state_t;
  localparam int PCT_MAX = 10;
  localparam logic [7:0] MASK_CAM0 = 8'h00;
  localparam logic [7:0] MASK_CAM1 = 8'hA5;
  function automatic logic [7:0] cam_mask(input int id);
    return (id == 1) ? MASK_CAM1 : MASK_CAM0;
  endfunction
endpackage

// File: rtl/cam_byte_streamer_if.sv
// cam_byte_streamer_if: 4-phase strobe/ack byte handshake toward the microcontroller.
interface cam_byte_streamer_if;
  logic [7:0] cur_byte;
  logic       strobe;
  logic       ack;
  modport master (output cur_byte, output strobe, input ack);
  modport slave  (input cur_byte, input strobe, output ack);
endinterface

// File: rtl/cam_byte_streamer_level.sv
// fill_level_tracker: byte count with percent in tenths, kept by a sub-counter instead of a divider.
module fill_level_tracker
  import cam_pkg::*;
#(
  parameter int BYTES_PER_PCT = 4,
  parameter int PTR_W         = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_clr,
  output logic [3:0] o_percent,
  output logic       o_full,
  output logic       o_empty
);
  localparam int DEPTH = PCT_MAX * BYTES_PER_PCT;
  localparam int SUB_W = (BYTES_PER_PCT > 1) ? $clog2(BYTES_PER_PCT) : 1;
  logic [PTR_W-1:0] r_count;
  logic [SUB_W-1:0] r_sub;
  logic [3:0]       r_pct;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_sub   <= '0;
      r_pct   <= '0;
    end else if (i_clr) begin
      r_count <= '0;
      r_sub   <= '0;
      r_pct   <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
      r_sub   <= (r_sub == SUB_W'(BYTES_PER_PCT - 1)) ? '0 : r_sub + 1'b1;
      if (r_sub == SUB_W'(BYTES_PER_PCT - 1) && r_pct < 4'(PCT_MAX)) r_pct <= r_pct + 1'b1;
    end else if (i_dec) begin
      r_count <= r_count - 1'b1;
      r_sub   <= (r_sub == '0) ? SUB_W'(BYTES_PER_PCT - 1) : r_sub - 1'b1;
      if (r_sub == '0) r_pct <= r_pct - 1'b1;
    end
  end
  assign o_percent = r_pct;
  assign o_full    = (r_count == PTR_W'(DEPTH));
  assign o_empty   = (r_count == '0);
endmodule

// File: rtl/cam_byte_streamer.sv
// cam_byte_streamer: per-camera circular byte FIFO filled with a fixed pattern while filming
// and drained to the microcontroller over a 4-phase strobe/ack handshake.
module cam_byte_streamer
  import cam_pkg::*;
#(
  parameter int BYTES_PER_PCT = 4,
  parameter int CAM_ID        = 0,
  parameter int PTR_W         = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fill,
  input  logic                  pause,
  input  logic                  download,
  input  logic                  flush,
  cam_byte_streamer_if.master   bus,
  output logic [3:0]            percent,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  done
);
  localparam int         DEPTH = PCT_MAX * BYTES_PER_PCT;
  localparam logic [7:0] MASK  = cam_mask(CAM_ID);
  state_t           r_state, w_next;
  logic [7:0]       r_mem [DEPTH];
  logic [7:0]       r_cur_byte;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic             w_wr, w_rd, w_clr, w_start_dl, w_idle_like;
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign w_start_dl  = download & !empty;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_FILL);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FILL: w_next = flush ? S_FLUSH : w_start_dl ? S_LOAD :
                               (fill & (!pause | r_state == S_FILL)) ? S_FILL : S_IDLE;
      S_LOAD:         w_next = S_PRESENT;
      S_PRESENT:      w_next = bus.ack ? S_RELEASE : S_PRESENT;
      // a flush seen while presenting is honoured here, once the byte is acknowledged
      S_RELEASE:      w_next = bus.ack ? S_RELEASE : empty ? S_IDLE : flush ? S_FLUSH :
                               (download & !pause) ? S_LOAD : S_IDLE;
      S_FLUSH:        w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end
  always_comb begin
    bus.strobe = (r_state == S_PRESENT);
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_RELEASE) & !bus.ack & empty;
    w_wr       = w_idle_like & fill & !pause & !full & !flush & !w_start_dl;
    w_rd       = (r_state == S_PRESENT) & bus.ack;
    w_clr      = (r_state == S_FLUSH);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cur_byte <= '0;
    end else begin
      if (w_clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= f_next(r_wr_ptr);
        if (w_rd) r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (r_state == S_LOAD) r_cur_byte <= r_mem[r_rd_ptr];
    end
  end
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= 8'(r_wr_ptr) ^ MASK;
  end
  assign bus.cur_byte = r_cur_byte;
  fill_level_tracker #(.BYTES_PER_PCT(BYTES_PER_PCT), .PTR_W(PTR_W)) u_level (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_inc     (w_wr),
    .i_dec     (w_rd),
    .i_clr     (w_clr),
    .o_percent (percent),
    .o_full    (full),
    .o_empty   (empty)
  );
endmodule

// File: tb/tb_cam_byte_streamer.sv
// tb_cam_byte_streamer: two cameras (CAM_ID 0 and 1) driven in lockstep against a queue model
// of the buffer contents; the bench plays the microcontroller side of the handshake.
module tb_cam_byte_streamer;
  logic clock = 1'b0;
  logic reset_n, fill, pause, download, flush, ack;
  logic [3:0] pct0, pct1;
  logic full0, full1, empty0, empty1, busy0, busy1, done0, done1;
  int n_tests = 0, n_fail = 0;
  int done_cnt0 = 0, done_cnt1 = 0;
  int q[$];
  int wr_idx = 0;

  always #5 clock = ~clock;

  cam_byte_streamer_if sif0 ();
  cam_byte_streamer_if sif1 ();
  assign sif0.ack = ack;
  assign sif1.ack = ack;

  cam_byte_streamer #(.BYTES_PER_PCT(4), .CAM_ID(0), .PTR_W(6)) dut0 (
    .clock(clock), .reset_n(reset_n), .fill(fill), .pause(pause), .download(download),
    .flush(flush), .bus(sif0), .percent(pct0), .full(full0), .empty(empty0),
    .busy(busy0), .done(done0));
  cam_byte_streamer #(.BYTES_PER_PCT(4), .CAM_ID(1), .PTR_W(6)) dut1 (
    .clock(clock), .reset_n(reset_n), .fill(fill), .pause(pause), .download(download),
    .flush(flush), .bus(sif1), .percent(pct1), .full(full1), .empty(empty1),
    .busy(busy1), .done(done1));

  always @(negedge clock) begin
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_status(input string tag);
    int e;
    e = (q.size() / 4 > 10) ? 10 : q.size() / 4;
    chk({tag, "_pct0"}, pct0, e);
    chk({tag, "_pct1"}, pct1, e);
    chk({tag, "_full"}, full0 & full1, q.size() == 40 ? 1 : 0);
    chk({tag, "_empty"}, empty0 | empty1, q.size() == 0 ? 1 : 0);
    chk({tag, "_busy"}, busy0 | busy1, 0);
  endtask

  task automatic model_clear();
    q.delete();
    wr_idx = 0;
  endtask

  task automatic do_fill(input int n, input bit rnd_pause);
    fill = 1'b1;
    for (int i = 0; i < n; i++) begin
      pause = rnd_pause && ($urandom_range(0, 3) == 0);
      if (!pause && q.size() < 40) begin
        q.push_back(wr_idx);
        wr_idx = (wr_idx + 1) % 40;
      end
      tick();
    end
    fill = 1'b0;
    pause = 1'b0;
    repeat (2) tick();
    chk_status("fill");
  endtask

  task automatic do_dl(input int k);
    int d0, d1, w, b;
    d0 = done_cnt0;
    d1 = done_cnt1;
    download = 1'b1;
    for (int i = 0; i < k; i++) begin
      w = 0;
      while (!sif0.strobe && w < 12) begin tick(); w++; end
      if (i == 0) chk("dl_latency", w, 2);
      chk("strobe_up", sif0.strobe & sif1.strobe, 1);
      if (!sif0.strobe) break;
      b = q.pop_front();
      chk("byte_cam0", sif0.cur_byte, b);
      chk("byte_cam1", sif1.cur_byte, b ^ 8'hA5);
      if (i == k - 1) download = 1'b0;
      tick();
      ack = 1'b1;
      w = 0;
      while (sif0.strobe && w < 12) begin tick(); w++; end
      chk("strobe_down", sif0.strobe | sif1.strobe, 0);
      tick();
      ack = 1'b0;
    end
    download = 1'b0;
    ack = 1'b0;
    repeat (3) tick();
    chk("dl_done0", done_cnt0 - d0, q.size() == 0 ? 1 : 0);
    chk("dl_done1", done_cnt1 - d1, q.size() == 0 ? 1 : 0);
    chk_status("dl");
  endtask

  task automatic wait_strobe();
    int w = 0;
    while (!sif0.strobe && w < 12) begin tick(); w++; end
    chk("wait_strobe", sif0.strobe, 1);
  endtask

  initial begin
    int d0, b;
    reset_n = 1'b0; fill = 1'b0; pause = 1'b0; download = 1'b0; flush = 1'b0; ack = 1'b0;
    #2;
    chk("rst_strobe", sif0.strobe, 0);
    chk("rst_byte", sif0.cur_byte, 0);
    chk("rst_done", done0, 0);
    chk_status("rst");
    tick();
    reset_n = 1'b1;
    tick();

    do_fill(12, 1'b0);
    do_dl(12);

    do_fill(50, 1'b0);
    do_dl(40);
    do_fill(3, 1'b0);
    do_dl(2);
    do_dl(1);

    // flush while a byte is presented: strobe must hold until ack, then buffer clears
    do_fill(9, 1'b0);
    d0 = done_cnt0;
    download = 1'b1;
    wait_strobe();
    b = q.pop_front();
    chk("fl_byte", sif0.cur_byte, b);
    flush = 1'b1;
    tick();
    chk("fl_hold", sif0.strobe, 1);
    tick();
    chk("fl_hold2", sif0.strobe, 1);
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    tick();
    flush = 1'b0;
    download = 1'b0;
    tick();
    model_clear();
    repeat (2) tick();
    chk("fl_no_done", done_cnt0 - d0, 0);
    chk_status("flush");

    // asynchronous reset in the middle of a presented byte
    do_fill(7, 1'b0);
    download = 1'b1;
    wait_strobe();
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_strobe", sif0.strobe | sif1.strobe, 0);
    chk("ar_empty", empty0 & empty1, 1);
    chk("ar_pct", pct0, 0);
    download = 1'b0;
    model_clear();
    tick();
    reset_n = 1'b1;
    tick();
    chk_status("ar");

    for (int it = 0; it < 12; it++) begin
      do_fill($urandom_range(1, 45), 1'b1);
      if (q.size() > 0) do_dl($urandom_range(1, q.size()));
    end
    if (q.size() > 0) do_dl(q.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cam_byte_streamer.md
Name: cam_byte_streamer

Overview:
- Per-camera byte buffer that sits between the camera control FSM and the microcontroller PIO interface.
- While filming, it fills an on-chip FIFO with a deterministic data pattern and reports the fill level in tenths (0-10) to the percent display and camera logic.
- On download, it streams bytes out to the microcontroller one at a time using a 4-phase strobe/ack handshake.
- On flush, it discards all contents.

Parameters:
- BYTES_PER_PCT, 4: bytes per 10% step. DEPTH = 10*BYTES_PER_PCT = 40.
- CAM_ID, 0: camera index. Pattern XOR mask is 8'h00 when CAM_ID=0, 8'hA5 when CAM_ID=1.
- PTR_W, 6: pointer/count width. Must satisfy 2^PTR_W >= DEPTH+1.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- fill  in  1  camera filming; write one byte per cycle when allowed.
- pause  in  1  freezes fill and download progress; a handshake already in flight still completes.
- download  in  1  request to stream the buffer to the microcontroller.
- flush  in  1  discard the buffer contents.
- ack  in  1  microcontroller has taken cur_byte (4-phase).
- cur_byte  out  8  byte presented to the microcontroller.
- strobe  out  1  cur_byte is valid.
- percent  out  4  fill level, 0..10.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- busy  out  1  state other than IDLE.
- done  out  1  one-cycle pulse when a download drains the buffer to empty.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; wr_ptr, rd_ptr, count, sub-counter, percent all 0.
  - cur_byte=8'h00; strobe=0; done=0; empty=1; full=0; busy=0.
  - Memory contents do not need resetting.
  - Reset asserted mid-handshake drops strobe immediately. The lost byte is not recovered.
- Storage is a circular FIFO of DEPTH bytes. Pointers wrap from DEPTH-1 to 0 (not a power of two).
- percent = count / BYTES_PER_PCT, saturating at 10. It is tracked with a sub-counter plus a tenths register, not a divider, and is updated in the same cycle that count changes.
- States: IDLE, FILL, LOAD, PRESENT, RELEASE, FLUSH. Priority on each cycle where a new action starts: flush > download > fill.
- IDLE:
  - flush -> FLUSH.
  - download & !empty -> LOAD.
  - fill & !pause -> FILL.
- FILL:
  - Each cycle with fill & !pause & !full: mem[wr_ptr] = wr_ptr[7:0]^mask (wr_ptr zero-extended); wr_ptr++ (wrap); count++.
  - At full, writes are ignored with no error.
  - fill deasserted -> IDLE.
  - flush or download preempt the state at the next edge with the IDLE priority.
- LOAD (1 cycle): cur_byte <= mem[rd_ptr]; go to PRESENT.
- PRESENT:
  - strobe=1 and cur_byte held stable.
  - On ack=1: strobe=0, rd_ptr++ (wrap), count--, go to RELEASE.
- RELEASE:
  - Wait for ack=0.
  - If count==0: pulse done, go to IDLE.
  - Else if download & !pause & !flush: go to LOAD.
  - Else go to IDLE. Deasserting download stops streaming after the current byte.
- FLUSH (1 cycle): count, pointers, sub-counter and percent set to 0; go to IDLE.
  - flush during PRESENT is deferred until RELEASE completes, so strobe is never withdrawn before ack.
- Simultaneous fill and download in IDLE: download wins. No reads and writes in the same cycle.
- Timing:
  - Latency from download asserted to strobe high is 2 cycles.
  - Minimum per-byte period is 4 cycles when ack responds within 1 cycle.
- ack asserted while not in PRESENT is ignored.

Decomposition:
- Shared package (cam_pkg):
  - State encoding enum.
  - PCT_MAX=10.
  - Mask constants 8'h00 and 8'hA5.
- One natural sub-module, fill_level_tracker: count, sub-counter and percent, with inc/dec/clear inputs, plus full/empty.
- FIFO memory and handshake FSM stay in the top module.

Test Plan:
- Reset, then fill=1 for 12 cycles (CAM_ID=0) -> count=12, percent=3, mem[0..11]=00..0B, empty=0.
- Fill for 50 cycles -> full=1 at 40, percent=10, count stays 40, wr_ptr=0 (wrapped).
- After 12-byte fill: download=1 with ack answering 1 cycle after strobe and dropping 1 cycle after strobe falls -> bytes 00..0B in order, strobe rises 2 cycles after download, done pulses once, empty=1, percent=0.
- CAM_ID=1, fill 3, download -> bytes A5, A4, A7. Deassert download during 2nd PRESENT -> 2nd byte completes, then IDLE with count=1.
- flush asserted while strobe=1 -> strobe held until ack; after RELEASE, FLUSH clears count=0, percent=0, no done pulse.
- reset_n low mid-PRESENT -> strobe=0 and count=0 immediately (asynchronous), state IDLE after release of reset.
